cpu_sequencer: RTL and testbench
================================

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 8, program counter width.
REQ-002 SHALL have parameter LAST_ADDR, default 8'd15, last instruction-memory address executed before halt.
REQ-003 SHALL have parameter LDR_OP, default 4'hA, opcode for a load.
REQ-004 SHALL have parameter STR_OP, default 4'hB, opcode for a store.
REQ-005 SHALL have parameter HALT_OP, default 4'hF, opcode that stops execution.
REQ-006 SHALL have ports: Clk  in  1  clock, all state changes on posedge.
REQ-007 Reset  in  1  synchronous, active-high reset.
REQ-008 Run  in  1  level; 1 = execute, 0 = pause at next instruction boundary.
REQ-009 Imem_Enable  out  1  instruction-memory enable; Imem_Addr  out  PC_W  fetch address (= PC).
REQ-010 Imem_Data  in  32  instruction word, combinational read.
REQ-011 Instr  out  32  instruction register feeding decode fields (Cond[31:28], OpCode[27:24], S[23]).
REQ-012 Mem_Addr  in  16  address from memory control; Dmem_Enable  out  1; Dmem_RW  out  1 (1 = read, 0 = write); Dmem_Addr  out  16.
REQ-013 New_Flag  in  4  ALU flags {N,Z,C,V}; Flag  out  4  architectural flags.
REQ-014 Reg_Write_En  out  1  register-bank write strobe; PC  out  PC_W; Busy  out  1; Halted  out  1; Retired  out  16  executed-instruction count.

Function
REQ-015 States SHALL be IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT; exactly one active per cycle.
REQ-016 IDLE: Busy=0; Run=1 -> FETCH; else stay.
REQ-017 FETCH: Imem_Enable=1, Imem_Addr=PC; Instr <= Imem_Data at exiting edge; -> DECODE.
REQ-018 DECODE: OpCode==HALT_OP -> HALT; else -> EXEC.
REQ-019 EXEC: condition evaluated from Instr[31:28] against current Flag: 0000 EQ (Z=1), 0001 NE (Z=0), 1010 GE (N==V), 1011 LT (N!=V), all other codes always pass.
REQ-020 EXEC, condition fails: no flag update, no write, no memory access, Retired unchanged; PC advance per REQ-024; 3-cycle instruction.
REQ-021 EXEC, condition passes: if S=1 Flag <= New_Flag at exiting edge; LDR_OP/STR_OP -> MEM; else -> WB.
REQ-022 MEM: Dmem_Enable=1, Dmem_Addr=Mem_Addr, Dmem_RW=1 for LDR_OP, 0 for STR_OP, one cycle; LDR -> WB; STR -> PC advance (no WB).
REQ-023 WB: Reg_Write_En=1 for exactly one cycle.
REQ-024 PC advance at exit of WB, STR MEM, or failed EXEC: if PC==LAST_ADDR -> HALT (PC unchanged); else PC <= PC+1, Retired incremented (passed instructions only), then -> FETCH if Run=1, else -> IDLE.
REQ-025 Latencies: ALU op 4 cycles, LDR 5, STR 4, skipped 3, HALT_OP 2 then HALT.
REQ-026 Retired SHALL saturate at 16'hFFFF.
REQ-027 Run=0 mid-instruction SHALL NOT abort it; pause only at the boundary; PC, Flag, Instr retained in IDLE.
REQ-028 HALT: Halted=1, Busy=0, all enables 0; exit only by Reset; Run ignored.
REQ-029 Busy=1 in FETCH, DECODE, EXEC, MEM, WB.
REQ-030 Imem_Enable, Dmem_Enable, Reg_Write_En SHALL be 0 outside the states named above; Dmem_RW=1 when Dmem_Enable=0.

Reset
REQ-031 Reset=1 at posedge SHALL force, regardless of state: state IDLE, PC=0, Instr=0, Flag=0, Retired=0, Halted=0, Busy=0, all enables 0, Dmem_RW=1, Dmem_Addr=0.
REQ-032 Reset mid-MEM or mid-WB SHALL suppress that access/write in the following cycle.

Verification
REQ-033 Reset, Run=1, Imem[0]=ALU op AL S=0 -> FETCH,DECODE,EXEC,WB; Reg_Write_En pulses once in cycle 4; PC=1; Retired=1.
REQ-034 Imem[1]=LDR, Mem_Addr=16'h0003 -> in MEM Dmem_Enable=1, Dmem_RW=1, Dmem_Addr=3; WB next cycle; STR same stimulus -> Dmem_RW=0, no WB.
REQ-035 Flag=4'b0000, Instr Cond=0000 (EQ) -> skipped: no Reg_Write_En, Retired unchanged, PC+1 after 3 cycles; S=1 ALU op with New_Flag=4'b0100 -> Flag=4'b0100.
REQ-036 Run dropped in EXEC -> instruction completes with WB, then IDLE with PC advanced; Run=1 resumes FETCH at that PC.
REQ-037 HALT_OP at address 5 -> Halted=1, PC=5; 16 straight-line ALU ops with LAST_ADDR=15 -> Halted=1, PC=15, Retired=16.
REQ-038 Reset asserted during MEM of STR -> next cycle Dmem_Enable=0, all outputs at REQ-031 values.

Source files
------------

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/decode/execute/mem/writeback sequencer
// with conditional execution, load/store phase, pause and halt control.
module cpu_sequencer #(
    parameter int              PC_W      = 8,
    parameter logic [PC_W-1:0] LAST_ADDR = 8'd15,
    parameter logic [3:0]      LDR_OP    = 4'hA,
    parameter logic [3:0]      STR_OP    = 4'hB,
    parameter logic [3:0]      HALT_OP   = 4'hF
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Run,
    output logic            Imem_Enable,
    output logic [PC_W-1:0] Imem_Addr,
    input  logic [31:0]     Imem_Data,
    output logic [31:0]     Instr,
    input  logic [15:0]     Mem_Addr,
    output logic            Dmem_Enable,
    output logic            Dmem_RW,
    output logic [15:0]     Dmem_Addr,
    input  logic [3:0]      New_Flag,
    output logic [3:0]      Flag,
    output logic            Reg_Write_En,
    output logic [PC_W-1:0] PC,
    output logic            Busy,
    output logic            Halted,
    output logic [15:0]     Retired
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [PC_W-1:0] pc_q;
    logic [31:0]     instr_q;
    logic [3:0]      flag_q;
    logic [15:0]     retired_q;

    logic [3:0] cond;
    logic [3:0] opcode;
    logic       s_bit;
    logic       cond_pass;
    logic       is_ldr;
    logic       is_mem;
    logic       at_last;

    logic load_instr;
    logic load_flag;
    logic advance;
    logic retire;

    assign cond    = instr_q[31:28];
    assign opcode  = instr_q[27:24];
    assign s_bit   = instr_q[23];
    assign is_ldr  = (opcode == LDR_OP);
    assign is_mem  = is_ldr || (opcode == STR_OP);
    assign at_last = (pc_q == LAST_ADDR);

    // Condition check against the flags held before this instruction.
    always_comb begin
        cond_pass = 1'b1;
        unique case (cond)
            4'b0000: cond_pass = flag_q[2];
            4'b0001: cond_pass = !flag_q[2];
            4'b1010: cond_pass = (flag_q[3] == flag_q[0]);
            4'b1011: cond_pass = (flag_q[3] != flag_q[0]);
            default: cond_pass = 1'b1;
        endcase
    end

    // State register; reset returns to IDLE from any state.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, phase strobes and datapath load enables.
    always_comb begin
        state_d      = state_q;
        load_instr   = 1'b0;
        load_flag    = 1'b0;
        advance      = 1'b0;
        retire       = 1'b0;
        Imem_Enable  = 1'b0;
        Dmem_Enable  = 1'b0;
        Reg_Write_En = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (Run) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                Imem_Enable = 1'b1;
                load_instr  = 1'b1;
                state_d     = DECODE;
            end
            DECODE: begin
                state_d = (opcode == HALT_OP) ? HALT : EXEC;
            end
            EXEC: begin
                if (cond_pass) begin
                    load_flag = s_bit;
                    state_d   = is_mem ? MEM : WB;
                end else begin
                    advance = 1'b1;
                end
            end
            MEM: begin
                Dmem_Enable = 1'b1;
                if (is_ldr) begin
                    state_d = WB;
                end else begin
                    advance = 1'b1;
                    retire  = 1'b1;
                end
            end
            WB: begin
                Reg_Write_En = 1'b1;
                advance      = 1'b1;
                retire       = 1'b1;
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Instruction boundary: stop at the last address, else
        // continue or pause depending on Run.
        if (advance) begin
            if (at_last) begin
                state_d = HALT;
            end else if (Run) begin
                state_d = FETCH;
            end else begin
                state_d = IDLE;
            end
        end
    end

    // Architectural registers: PC, instruction, flags, retire count.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_q      <= '0;
            instr_q   <= '0;
            flag_q    <= '0;
            retired_q <= '0;
        end else begin
            if (load_instr) begin
                instr_q <= Imem_Data;
            end
            if (load_flag) begin
                flag_q <= New_Flag;
            end
            if (advance && !at_last) begin
                pc_q <= pc_q + PC_W'(1);
            end
            if (retire && (retired_q != 16'hFFFF)) begin
                retired_q <= retired_q + 16'd1;
            end
        end
    end

    assign Imem_Addr = pc_q;
    assign PC        = pc_q;
    assign Instr     = instr_q;
    assign Flag      = flag_q;
    assign Retired   = retired_q;
    assign Dmem_RW   = !(Dmem_Enable && !is_ldr);
    assign Dmem_Addr = Dmem_Enable ? Mem_Addr : 16'h0000;
    assign Halted    = (state_q == HALT);
    assign Busy      = (state_q == FETCH) || (state_q == DECODE) ||
                       (state_q == EXEC)  || (state_q == MEM)    ||
                       (state_q == WB);

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: random programs run against an instruction-level
// reference model that predicts each cycle's control outputs.
module tb_cpu_sequencer;

    localparam logic [7:0] LAST = 8'd15;
    localparam logic [3:0] LDR  = 4'hA;
    localparam logic [3:0] STR  = 4'hB;
    localparam logic [3:0] HLT  = 4'hF;
    localparam int         BUDGET = 3000;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Run = 1'b0;
    logic        Imem_Enable;
    logic [7:0]  Imem_Addr;
    logic [31:0] Imem_Data;
    logic [31:0] Instr;
    logic [15:0] Mem_Addr = 16'h0;
    logic        Dmem_Enable;
    logic        Dmem_RW;
    logic [15:0] Dmem_Addr;
    logic [3:0]  New_Flag = 4'h0;
    logic [3:0]  Flag;
    logic        Reg_Write_En;
    logic [7:0]  PC;
    logic        Busy;
    logic        Halted;
    logic [15:0] Retired;

    logic [31:0] prog [0:15];

    int n_checks = 0;
    int n_fails  = 0;

    typedef enum {K_F, K_D, K_E, K_ML, K_MS, K_W} kind_t;

    cpu_sequencer dut (
        .Clk(Clk),
        .Reset(Reset),
        .Run(Run),
        .Imem_Enable(Imem_Enable),
        .Imem_Addr(Imem_Addr),
        .Imem_Data(Imem_Data),
        .Instr(Instr),
        .Mem_Addr(Mem_Addr),
        .Dmem_Enable(Dmem_Enable),
        .Dmem_RW(Dmem_RW),
        .Dmem_Addr(Dmem_Addr),
        .New_Flag(New_Flag),
        .Flag(Flag),
        .Reg_Write_En(Reg_Write_En),
        .PC(PC),
        .Busy(Busy),
        .Halted(Halted),
        .Retired(Retired)
    );

    assign Imem_Data = (Imem_Addr < 8'd16) ? prog[Imem_Addr[3:0]] : 32'h0;

    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, required end of test");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_ctrl(input string tag, input logic busy,
                               input logic ien, input logic den,
                               input logic rw, input logic wr,
                               input logic hlt);
        check({tag, "_busy"}, 32'(Busy), 32'(busy));
        check({tag, "_imem_en"}, 32'(Imem_Enable), 32'(ien));
        check({tag, "_dmem_en"}, 32'(Dmem_Enable), 32'(den));
        check({tag, "_dmem_rw"}, 32'(Dmem_RW), 32'(rw));
        check({tag, "_reg_we"}, 32'(Reg_Write_En), 32'(wr));
        check({tag, "_halted"}, 32'(Halted), 32'(hlt));
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive_rand();
        New_Flag = 4'($urandom);
        Mem_Addr = 16'($urandom);
    endtask

    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
        case (c)
            4'h0: return f[2];
            4'h1: return !f[2];
            4'hA: return f[3] == f[0];
            4'hB: return f[3] != f[0];
            default: return 1'b1;
        endcase
    endfunction

    task automatic do_reset();
        Reset = 1'b1;
        Run = 1'($urandom);
        drive_rand();
        tick();
        expect_ctrl("reset", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("reset_pc", 32'(PC), 32'h0);
        check("reset_instr", Instr, 32'h0);
        check("reset_flag", 32'(Flag), 32'h0);
        check("reset_retired", 32'(Retired), 32'h0);
        check("reset_dmem_addr", 32'(Dmem_Addr), 32'h0);
        Reset = 1'b0;
    endtask

    task automatic gen_program();
        logic [3:0] c;
        logic [3:0] o;
        for (int i = 0; i < 16; i++) begin
            case ($urandom_range(0, 5))
                0: c = 4'h0;
                1: c = 4'h1;
                2: c = 4'hA;
                3: c = 4'hB;
                4: c = 4'hE;
                default: c = 4'($urandom);
            endcase
            o = 4'($urandom);
            if (o == HLT && $urandom_range(0, 3) != 0) o = LDR;
            prog[i] = {c, o, 1'($urandom), 23'($urandom)};
        end
    endtask

    // Runs prog from reset until the model predicts a halt.
    task automatic run_program();
        logic [7:0]  m_pc = 8'h0;
        logic [3:0]  m_flag = 4'h0;
        logic [15:0] m_ret = 16'h0;
        logic [31:0] word;
        logic [3:0]  op;
        logic [3:0]  nf;
        bit          pass;
        bit          in_idle = 1'b1;
        bit          done = 1'b0;
        bit          last_run = 1'b0;
        int          cycles = 0;
        kind_t       seq[$];
        nf = 4'h0;
        do_reset();
        while (!done && cycles < BUDGET) begin
            if (in_idle) begin
                Run = ($urandom_range(0, 9) < 6);
                drive_rand();
                #1;
                expect_ctrl("idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
                check("idle_pc", 32'(PC), 32'(m_pc));
                check("idle_flag", 32'(Flag), 32'(m_flag));
                last_run = Run;
                tick();
                cycles++;
                if (last_run) in_idle = 1'b0;
            end else begin
                word = prog[m_pc[3:0]];
                op = word[27:24];
                pass = cond_ok(word[31:28], m_flag);
                seq.delete();
                seq.push_back(K_F);
                seq.push_back(K_D);
                if (op != HLT) begin
                    seq.push_back(K_E);
                    if (pass) begin
                        if (op == LDR) begin
                            seq.push_back(K_ML);
                            seq.push_back(K_W);
                        end else if (op == STR) begin
                            seq.push_back(K_MS);
                        end else begin
                            seq.push_back(K_W);
                        end
                    end
                end
                foreach (seq[i]) begin
                    Run = ($urandom_range(0, 9) < 6);
                    drive_rand();
                    #1;
                    check("pc", 32'(PC), 32'(m_pc));
                    check("flag", 32'(Flag), 32'(m_flag));
                    check("retired", 32'(Retired), 32'(m_ret));
                    case (seq[i])
                        K_F: begin
                            expect_ctrl("fetch", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
                            check("imem_addr", 32'(Imem_Addr), 32'(m_pc));
                        end
                        K_D: begin
                            expect_ctrl("decode", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
                            check("instr", Instr, word);
                        end
                        K_E: begin
                            expect_ctrl("exec", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
                            nf = New_Flag;
                        end
                        K_ML: begin
                            expect_ctrl("mem_ld", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
                            check("ld_dmem_addr", 32'(Dmem_Addr), 32'(Mem_Addr));
                        end
                        K_MS: begin
                            expect_ctrl("mem_st", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
                            check("st_dmem_addr", 32'(Dmem_Addr), 32'(Mem_Addr));
                        end
                        default: begin
                            expect_ctrl("wb", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
                        end
                    endcase
                    last_run = Run;
                    tick();
                    cycles++;
                    if (seq[i] == K_E && pass && word[23]) m_flag = nf;
                end
                if (op == HLT) begin
                    done = 1'b1;
                end else begin
                    if (pass && m_ret != 16'hFFFF) m_ret++;
                    if (m_pc == LAST) begin
                        done = 1'b1;
                    end else begin
                        m_pc++;
                        in_idle = !last_run;
                    end
                end
            end
        end
        check("budget", 32'(done), 32'h1);
        for (int k = 0; k < 3; k++) begin
            Run = 1'($urandom);
            drive_rand();
            #1;
            expect_ctrl("halt", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
            check("halt_pc", 32'(PC), 32'(m_pc));
            check("halt_flag", 32'(Flag), 32'(m_flag));
            check("halt_retired", 32'(Retired), 32'(m_ret));
            tick();
        end
    endtask

    initial begin
        // Straight-line always-execute ALU ops up to the last address.
        for (int i = 0; i < 16; i++) begin
            prog[i] = {4'hE, 4'h2, 1'b0, 23'($urandom)};
        end
        run_program();
        check("line_pc", 32'(PC), 32'd15);
        check("line_retired", 32'(Retired), 32'd16);
        check("line_halted", 32'(Halted), 32'h1);

        // EQ skip on cleared flags, then a halt opcode at address 5.
        prog[0] = {4'h0, 4'h2, 1'b0, 23'h0};
        for (int i = 1; i < 5; i++) begin
            prog[i] = {4'hE, 4'h3, 1'($urandom), 23'($urandom)};
        end
        prog[5] = {4'h0, HLT, 1'b0, 23'h0};
        run_program();
        check("halt5_pc", 32'(PC), 32'd5);
        check("halt5_retired", 32'(Retired), 32'd4);

        for (int r = 0; r < 8; r++) begin
            gen_program();
            run_program();
        end

        // Flag-setting ALU op, then a store interrupted by reset in MEM.
        prog[0] = {4'hE, 4'h3, 1'b1, 23'h0};
        prog[1] = {4'hE, STR, 1'b0, 23'h0};
        do_reset();
        Run = 1'b1;
        New_Flag = 4'b0100;
        Mem_Addr = 16'h0003;
        repeat (8) tick();
        check("st_mem_en", 32'(Dmem_Enable), 32'h1);
        check("st_mem_rw", 32'(Dmem_RW), 32'h0);
        check("st_mem_addr", 32'(Dmem_Addr), 32'h3);
        check("st_flag", 32'(Flag), 32'h4);
        check("st_retired", 32'(Retired), 32'h1);
        Reset = 1'b1;
        tick();
        expect_ctrl("mem_rst", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("mem_rst_pc", 32'(PC), 32'h0);
        check("mem_rst_flag", 32'(Flag), 32'h0);
        check("mem_rst_instr", Instr, 32'h0);
        check("mem_rst_retired", 32'(Retired), 32'h0);
        check("mem_rst_dmem_addr", 32'(Dmem_Addr), 32'h0);
        Reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
